bcsa_share_arb: RTL and testbench
=================================

Name: bcsa_share_arb

Overview:
- Shares one 32-bit approximate block carry-select adder (bcsa32_4, instantiated internally) among NREQ requesters.
- Round-robin arbitration; valid/ready handshakes on every request and on the single response port.
- Registers the approximate 33-bit sum, tagged with the requester id.
- Includes an online accuracy monitor: compares each approximate result with an exact a+b and keeps saturating grant and error counters, used to characterise the approximate adder in-system.

Parameters:
- NREQ, 4, number of requesters (2..8); ID_W = clog2(NREQ), derived.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req_valid  input  NREQ  request i presents operands.
- req_ready  output  NREQ  request i accepted this cycle.
- req_a  input  NREQ*32  operand A, slice i = [32*i+31:32*i].
- req_b  input  NREQ*32  operand B, same slicing.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer takes the response.
- rsp_sum  output  33  approximate sum from bcsa32_4.
- rsp_id  output  ID_W  index of the requester that produced rsp_sum.
- rsp_err  output  1  rsp_sum differs from exact 33-bit a+b.
- clr_stats  input  1  synchronous clear of the counters.
- grant_cnt  output  CNT_W  accepted requests since reset/clear.
- err_cnt  output  CNT_W  accepted requests with rsp_err=1.

Behaviour:
- Reset (rst_n=0, async): rsp_valid=0, rsp_sum=0, rsp_id=0, rsp_err=0, rr_ptr=0, grant_cnt=0, err_cnt=0. req_ready is combinational and is 0 during reset.
- accept = !rsp_valid | rsp_ready. The output stage is one slot deep; issuing into a slot that is draining in the same cycle is allowed, so full throughput is 1 result per cycle.
- Arbitration:
  - Grant the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - req_ready[i] = accept & grant[i]. At most one ready bit is high per cycle.
  - req_ready never depends on req_valid of the same requester beyond the grant search.
- On a handshake (req_valid[i] & req_ready[i]):
  - Next cycle: rsp_valid=1, rsp_sum=bcsa32_4(a_i,b_i), rsp_id=i, rsp_err=(rsp_sum != {1'b0,a_i}+{1'b0,b_i}).
  - rr_ptr <= (i+1) mod NREQ.
- Latency: exactly 1 cycle from handshake to rsp_valid.
- rr_ptr does not change when there is no grant.
- Backpressure: while rsp_valid & !rsp_ready, rsp_sum, rsp_id and rsp_err hold stable and every req_ready=0.
- rsp_valid drops only after a cycle with rsp_ready=1 and no new grant.
- Adder datapath: the adder is purely combinational between the muxed operands and the response register. The mux selects by grant index. The exact reference sum is computed in parallel and is never output.
- Counters:
  - On a handshake, grant_cnt += 1 and err_cnt += (computed error bit). The increment is evaluated at the issue cycle, so the counter is visible one cycle later, aligned with rsp_valid.
  - Both counters saturate at 2^CNT_W-1 (no wrap).
  - clr_stats=1 zeroes both counters next cycle and takes priority over a same-cycle increment; that event is not counted.
  - clr_stats does not affect the arbitration or response state.
- Operand stability:
  - Requesters must hold a/b while valid and not ready.
  - A requester may drop valid before it is granted; the grant is then re-evaluated each cycle with no penalty.
- Mid-operation reset: a pending response is discarded; nothing is replayed.

Test Plan:
- Single request, no error: req 0 a=0x00000003 b=0x00000004, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=0x000000007, rsp_id=0, rsp_err=0, grant_cnt=1, err_cnt=0.
- Speculation miss: req 2 a=0x0000000F b=0x00000001 -> rsp_sum=0x000000000, rsp_err=1 (exact 0x10); err_cnt=1.
- Long propagate: a=0xFFFFFFFF b=0x00000001 -> rsp_sum=0x0FFFFFF00, rsp_err=1 (exact 0x100000000).
- Fairness: all 4 valid continuously, rsp_ready=1, rr_ptr=0 -> grants in order 0,1,2,3,0,... one per cycle; after 8 cycles grant_cnt=8.
- Backpressure: response held with rsp_ready=0 for 3 cycles -> all req_ready=0 and rsp outputs stable. Raise rsp_ready -> the next grant issues in the same cycle and the new result appears next cycle with no bubble.
- Saturation/clear/reset:
  - CNT_W=4, 20 erroring requests -> both counters stick at 15.
  - clr_stats together with a handshake -> counters read 0.
  - rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately and rr_ptr=0.

Source files
------------

// File: rtl/bcsa_share_arb.sv
// Shared approximate block carry-select adder with round-robin arbitration.
// Tracks grant and accuracy statistics for in-system characterisation.

module bcsa32_4 (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [32:0] o_sum
);
    logic [4:0] w_loc [8];
    logic [4:0] w_blk [8];
    logic [7:0] w_cin;

    // A block only takes the previous block's local carry when it fully
    // propagates; otherwise its carry-in is speculated as zero.
    for (genvar k = 0; k < 8; k++) begin : g_blk
        assign w_loc[k] = {1'b0, i_a[4*k +: 4]} + {1'b0, i_b[4*k +: 4]};
        if (k == 0) begin : g_first
            assign w_cin[k] = 1'b0;
        end else begin : g_rest
            assign w_cin[k] = (&(i_a[4*k +: 4] ^ i_b[4*k +: 4]))
                            & w_loc[k-1][4];
        end
        assign w_blk[k] = w_loc[k] + {4'd0, w_cin[k]};
        assign o_sum[4*k +: 4] = w_blk[k][3:0];
    end

    assign o_sum[32] = w_blk[7][4];
endmodule

module bcsa_share_arb #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 16,
    localparam int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [32:0]       rsp_sum,
    output logic [ID_W-1:0]   rsp_id,
    output logic              rsp_err,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  grant_cnt,
    output logic [CNT_W-1:0]  err_cnt
);
    logic              r_rsp_valid;
    logic [32:0]       r_rsp_sum;
    logic [ID_W-1:0]   r_rsp_id;
    logic              r_rsp_err;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [CNT_W-1:0]  r_grant_cnt;
    logic [CNT_W-1:0]  r_err_cnt;

    logic              w_accept;
    logic              w_gnt_vld;
    logic [ID_W-1:0]   w_gnt_id;
    logic [NREQ-1:0]   w_gnt_oh;
    logic              w_fire;
    logic [31:0]       w_a;
    logic [31:0]       w_b;
    logic [32:0]       w_sum;
    logic [32:0]       w_exact;
    logic              w_err;
    logic [ID_W-1:0]   w_ptr_nxt;

    assign w_accept = rst_n & (~r_rsp_valid | rsp_ready);

    // Round-robin search from r_rr_ptr; the nearest valid requester wins.
    always_comb begin
        logic [ID_W:0] v_idx;
        v_idx     = '0;
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            v_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (v_idx >= (ID_W+1)'(NREQ))
                v_idx = v_idx - (ID_W+1)'(NREQ);
            if (req_valid[v_idx[ID_W-1:0]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = v_idx[ID_W-1:0];
            end
        end
    end

    // Operand mux steered by the granted index.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_a = req_a[32*i +: 32];
                w_b = req_b[32*i +: 32];
            end
        end
    end

    assign w_gnt_oh  = w_gnt_vld
                     ? ({{(NREQ-1){1'b0}}, 1'b1} << w_gnt_id)
                     : '0;
    assign req_ready = w_accept ? w_gnt_oh : '0;
    assign w_fire    = w_accept & w_gnt_vld;

    bcsa32_4 u_add (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_sum (w_sum)
    );

    assign w_exact   = {1'b0, w_a} + {1'b0, w_b};
    assign w_err     = (w_sum != w_exact);
    assign w_ptr_nxt = (w_gnt_id == ID_W'(NREQ - 1))
                     ? '0 : w_gnt_id + ID_W'(1);

    // One-deep response slot plus round-robin pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_sum   <= '0;
            r_rsp_id    <= '0;
            r_rsp_err   <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_fire) begin
            r_rsp_valid <= 1'b1;
            r_rsp_sum   <= w_sum;
            r_rsp_id    <= w_gnt_id;
            r_rsp_err   <= w_err;
            r_rr_ptr    <= w_ptr_nxt;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // Saturating statistics; a clear wins over a same-cycle grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (clr_stats) begin
            r_grant_cnt <= '0;
            r_err_cnt   <= '0;
        end else if (w_fire) begin
            if (r_grant_cnt != '1)
                r_grant_cnt <= r_grant_cnt + CNT_W'(1);
            if (w_err && (r_err_cnt != '1))
                r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_sum   = r_rsp_sum;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;
    assign grant_cnt = r_grant_cnt;
    assign err_cnt   = r_err_cnt;
endmodule

// File: tb/tb_bcsa_share_arb.sv
// Bench for bcsa_share_arb: vector table, scoreboard and reference model.
// A second instance with 4-bit counters exercises saturation.

module tb_bcsa_share_arb;
    localparam int NREQ = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [3:0]       req_valid = '0;
    logic [3:0]       req_ready;
    logic [3:0]       req_ready4;
    logic [127:0]     req_a = '0;
    logic [127:0]     req_b = '0;
    logic             rsp_valid, rsp_valid4;
    logic             rsp_ready = 1'b0;
    logic [32:0]      rsp_sum, rsp_sum4;
    logic [1:0]       rsp_id, rsp_id4;
    logic             rsp_err, rsp_err4;
    logic             clr_stats = 1'b0;
    logic [15:0]      grant_cnt, err_cnt;
    logic [3:0]       grant_cnt4, err_cnt4;

    always #5 clk = ~clk;

    bcsa_share_arb #(.NREQ(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .clr_stats(clr_stats),
        .grant_cnt(grant_cnt), .err_cnt(err_cnt)
    );

    bcsa_share_arb #(.NREQ(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready4),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum4), .rsp_id(rsp_id4), .rsp_err(rsp_err4),
        .clr_stats(clr_stats),
        .grant_cnt(grant_cnt4), .err_cnt(err_cnt4)
    );

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [32:0] sum;
    } vec_t;

    typedef struct {
        logic [32:0] sum;
        int          id;
        logic        err;
    } exp_t;

    vec_t        tbl [8];
    exp_t        sb [$];
    logic [32:0] exp_sum_r [4];
    logic        exp_err_r [4];

    int n_chk = 0;
    int n_err = 0;

    int m_ptr = 0;
    bit m_vld = 1'b0;
    int m_g = 0, m_e = 0, m_g4 = 0, m_e4 = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic present(int id, logic [31:0] a, logic [31:0] b,
                           logic [32:0] s);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        exp_sum_r[id] = s;
        exp_err_r[id] = (s != ({1'b0, a} + {1'b0, b}));
        req_valid[id] = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model and scoreboard, evaluated mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_rsp_sum", 64'(rsp_sum), 64'd0);
            chk("rst_rsp_id", 64'(rsp_id), 64'd0);
            chk("rst_rsp_err", 64'(rsp_err), 64'd0);
            chk("rst_req_ready", 64'(req_ready), 64'd0);
            chk("rst_grant_cnt", 64'(grant_cnt), 64'd0);
            chk("rst_err_cnt", 64'(err_cnt), 64'd0);
            m_ptr = 0; m_vld = 1'b0;
            m_g = 0; m_e = 0; m_g4 = 0; m_e4 = 0;
            sb.delete();
        end else begin
            bit   acc, found;
            int   gid;
            logic [3:0] erdy;
            exp_t e;
            chk("rsp_valid", 64'(rsp_valid), 64'(m_vld));
            chk("rsp_valid4", 64'(rsp_valid4), 64'(m_vld));
            chk("grant_cnt", 64'(grant_cnt), 64'(m_g));
            chk("err_cnt", 64'(err_cnt), 64'(m_e));
            chk("grant_cnt4", 64'(grant_cnt4), 64'(m_g4));
            chk("err_cnt4", 64'(err_cnt4), 64'(m_e4));
            if (m_vld && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 64'd0, 64'd1);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_sum", 64'(rsp_sum), 64'(e.sum));
                    chk("rsp_id", 64'(rsp_id), 64'(e.id));
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                    chk("rsp_sum4", 64'(rsp_sum4), 64'(e.sum));
                end
            end
            acc = !m_vld || rsp_ready;
            found = 1'b0;
            gid = 0;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (!found && req_valid[j]) begin
                    found = 1'b1;
                    gid = j;
                end
            end
            erdy = (acc && found) ? 4'(1 << gid) : 4'd0;
            chk("req_ready", 64'(req_ready), 64'(erdy));
            chk("req_ready4", 64'(req_ready4), 64'(erdy));
            if (acc && found) begin
                e.sum = exp_sum_r[gid];
                e.id  = gid;
                e.err = exp_err_r[gid];
                sb.push_back(e);
                m_ptr = (gid + 1) % NREQ;
                m_vld = 1'b1;
            end else if (rsp_ready) begin
                m_vld = 1'b0;
            end
            if (clr_stats) begin
                m_g = 0; m_e = 0; m_g4 = 0; m_e4 = 0;
            end else if (acc && found) begin
                if (m_g < 65535) m_g++;
                if (m_g4 < 15) m_g4++;
                if (exp_err_r[gid]) begin
                    if (m_e < 65535) m_e++;
                    if (m_e4 < 15) m_e4++;
                end
            end
        end
    end

    initial begin
        tbl[0] = '{0, 32'h00000003, 32'h00000004, 33'h000000007};
        tbl[1] = '{2, 32'h0000000F, 32'h00000001, 33'h000000000};
        tbl[2] = '{1, 32'hFFFFFFFF, 32'h00000001, 33'h0FFFFFF00};
        tbl[3] = '{3, 32'h12345678, 32'h11111111, 33'h023456789};
        tbl[4] = '{0, 32'hFFFFFFFF, 32'hFFFFFFFF, 33'h1EEEEEEEE};
        tbl[5] = '{2, 32'h80000000, 32'h80000000, 33'h100000000};
        tbl[6] = '{1, 32'h000000F8, 32'h00000008, 33'h000000000};
        tbl[7] = '{3, 32'h0000001F, 32'h00000001, 33'h000000010};
        for (int i = 0; i < 4; i++) begin
            exp_sum_r[i] = '0;
            exp_err_r[i] = 1'b0;
        end

        repeat (2) @(negedge clk);
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;

        // Table of single requests, issued back to back.
        for (int i = 0; i < 8; i++) begin
            req_valid = '0;
            present(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sum);
            step();
        end
        req_valid = '0;
        step();
        @(negedge clk);
        chk("tbl_grant_cnt", 64'(grant_cnt), 64'd8);
        chk("tbl_err_cnt", 64'(err_cnt), 64'd5);

        // Fairness: all requesters valid, rr_ptr back at 0.
        step();
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        for (int i = 0; i < 4; i++)
            present(i, 32'(i + 1), 32'h10, 33'(i + 17));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("fair_order", 64'(req_ready), 64'(1 << (c % 4)));
            step();
        end
        req_valid = '0;
        @(negedge clk);
        chk("fair_grant_cnt", 64'(grant_cnt), 64'd8);

        // Backpressure: hold a response for three cycles.
        step();
        present(0, 32'h100, 32'h200, 33'h300);
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        present(1, 32'h5, 32'h6, 33'hB);
        present(2, 32'h7, 32'h8, 33'hF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_sum", 64'(rsp_sum), 64'h300);
            chk("bp_id", 64'(rsp_id), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 64'(req_ready), 64'h2);
        step();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("bp_nobubble_v", 64'(rsp_valid), 64'd1);
        chk("bp_nobubble_id", 64'(rsp_id), 64'd1);
        step();
        req_valid = '0;
        step();

        // Saturation of the 4-bit counters with erroring requests.
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        present(2, 32'h0000000F, 32'h00000001, 33'h0);
        repeat (20) step();
        req_valid = '0;
        @(negedge clk);
        chk("sat_grant4", 64'(grant_cnt4), 64'd15);
        chk("sat_err4", 64'(err_cnt4), 64'd15);
        chk("sat_grant16", 64'(grant_cnt), 64'd20);
        chk("sat_err16", 64'(err_cnt), 64'd20);

        // Clear together with a handshake.
        step();
        clr_stats = 1'b1;
        present(3, 32'h3, 32'h4, 33'h7);
        step();
        clr_stats = 1'b0;
        req_valid = '0;
        @(negedge clk);
        chk("clr_grant", 64'(grant_cnt), 64'd0);
        chk("clr_err", 64'(err_cnt), 64'd0);
        chk("clr_rsp_valid", 64'(rsp_valid), 64'd1);

        // Reset while a response is pending.
        step();
        present(1, 32'h1, 32'h1, 33'h2);
        step();
        req_valid = '0;
        rsp_ready = 1'b0;
        #1;
        chk("mid_pending", 64'(rsp_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        step();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++)
            present(i, 32'(i), 32'h0, 33'(i));
        @(negedge clk);
        chk("mid_ptr_zero", 64'(req_ready), 64'h1);
        step();
        req_valid = '0;
        repeat (3) step();
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule
